// File: rtl/gpio_intr_pkg.sv
// Shared types and defaults for the GPIO interrupt engine.
// The mode decode lives here so the top and any future users agree on it.
package gpio_intr_pkg;

    localparam int NUM_GPIO_DEF    = 256;
    localparam int GROUP_SIZE_DEF  = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_CNT_W_DEF  = 8;

    typedef enum logic [2:0] {
        INTR_RISE       = 3'b000,
        INTR_FALL       = 3'b001,
        INTR_BOTH       = 3'b010,
        INTR_LEVEL_HIGH = 3'b011,
        INTR_LEVEL_LOW  = 3'b100
    } intr_mode_e;

    // Reserved encodings (101-111) fall into the default branch and never detect.
    function automatic logic mode_detect(input logic [2:0] mode,
                                         input logic       q,
                                         input logic       prev);
        logic hit;
        hit = 1'b0;
        case (mode)
            INTR_RISE:       hit = ~prev & q;
            INTR_FALL:       hit = prev & ~q;
            INTR_BOTH:       hit = prev ^ q;
            INTR_LEVEL_HIGH: hit = q;
            INTR_LEVEL_LOW:  hit = ~q;
            default:         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_intr_pin_filter.sv
// One pin's synchroniser and glitch filter, producing filt_q and its one-cycle delay.
// During the prime phase both registers follow the synchroniser directly.
module gpio_intr_pin_filter
    import gpio_intr_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CNT_W  = FILT_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pad,
    input  logic                  filt_enable,
    input  logic [FILT_CNT_W-1:0] filt_threshold,
    input  logic                  prime,
    output logic                  filt_q,
    output logic                  filt_prev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [FILT_CNT_W-1:0]  cnt;
    logic [FILT_CNT_W-1:0]  thr_eff;
    logic [FILT_CNT_W-1:0]  thr_last;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // A zero threshold or a disabled filter both behave as a one-cycle pass-through.
    always_comb begin
        thr_eff = FILT_CNT_W'(1);
        if (filt_enable && (filt_threshold != '0)) begin
            thr_eff = filt_threshold;
        end
        thr_last = thr_eff - FILT_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    // Using >= lets a lowered threshold take effect on a count already past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q    <= 1'b0;
            filt_prev <= 1'b0;
            cnt       <= '0;
        end else if (prime) begin
            filt_q    <= sync_out;
            filt_prev <= sync_out;
            cnt       <= '0;
        end else begin
            filt_prev <= filt_q;
            if (sync_out == filt_q) begin
                cnt <= '0;
            end else if (cnt >= thr_last) begin
                filt_q <= sync_out;
                cnt    <= '0;
            end else begin
                cnt <= cnt + FILT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_intr_filter_ctrl.sv
// GPIO interrupt engine: per-pin filtering, mode detection, sticky W1C status
// and per-group interrupt outputs.
module gpio_intr_filter_ctrl
    import gpio_intr_pkg::*;
#(
    parameter int NUM_GPIO    = NUM_GPIO_DEF,
    parameter int GROUP_SIZE  = GROUP_SIZE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CNT_W  = FILT_CNT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_GPIO-1:0]            gpio_in_data,
    input  logic [NUM_GPIO-1:0]            intr_enable,
    input  logic [3*NUM_GPIO-1:0]          intr_mode,
    input  logic [NUM_GPIO-1:0]            filt_enable,
    input  logic [FILT_CNT_W-1:0]          filt_threshold,
    input  logic [NUM_GPIO-1:0]            status_clr,
    output logic [NUM_GPIO-1:0]            gpio_in_filt,
    output logic [NUM_GPIO-1:0]            intr_status,
    output logic [NUM_GPIO/GROUP_SIZE-1:0] group_intr
);

    localparam int NUM_GROUPS = NUM_GPIO / GROUP_SIZE;
    localparam int PRIME_LEN  = SYNC_STAGES + 1;
    localparam int PRIME_W    = $clog2(PRIME_LEN + 1);

    logic [PRIME_W-1:0]  prime_cnt;
    logic                prime;
    logic [NUM_GPIO-1:0] filt_q;
    logic [NUM_GPIO-1:0] filt_prev;
    logic [NUM_GPIO-1:0] det;

    assign prime = (prime_cnt != PRIME_W'(PRIME_LEN));

    // Counts the cycles after reset release, then parks at PRIME_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
        end else if (prime) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        gpio_intr_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CNT_W  (FILT_CNT_W)
        ) u_filter (
            .clk            (clk),
            .rst_n          (rst_n),
            .pad            (gpio_in_data[i]),
            .filt_enable    (filt_enable[i]),
            .filt_threshold (filt_threshold),
            .prime          (prime),
            .filt_q         (filt_q[i]),
            .filt_prev      (filt_prev[i])
        );
    end

    assign gpio_in_filt = filt_q;

    always_comb begin
        det = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            det[i] = intr_enable[i] & ~prime &
                     mode_detect(intr_mode[3*i +: 3], filt_q[i], filt_prev[i]);
        end
    end

    // A same-cycle detection outranks the clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_status <= '0;
        end else begin
            intr_status <= det | (intr_status & ~status_clr);
        end
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        assign group_intr[g] = |intr_status[g*GROUP_SIZE +: GROUP_SIZE];
    end

endmodule

// File: tb/tb_gpio_intr_filter_ctrl.sv
// Directed bench for gpio_intr_filter_ctrl with hand-derived cycle timing.
module tb_gpio_intr_filter_ctrl;

    localparam int N  = 256;
    localparam int NG = 8;
    localparam int FW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    gpio_in_data;
    logic [N-1:0]    intr_enable;
    logic [3*N-1:0]  intr_mode;
    logic [N-1:0]    filt_enable;
    logic [FW-1:0]   filt_threshold;
    logic [N-1:0]    status_clr;
    logic [N-1:0]    gpio_in_filt;
    logic [N-1:0]    intr_status;
    logic [NG-1:0]   group_intr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_intr_filter_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .gpio_in_data   (gpio_in_data),
        .intr_enable    (intr_enable),
        .intr_mode      (intr_mode),
        .filt_enable    (filt_enable),
        .filt_threshold (filt_threshold),
        .status_clr     (status_clr),
        .gpio_in_filt   (gpio_in_filt),
        .intr_status    (intr_status),
        .group_intr     (group_intr)
    );

    task automatic checkOutput(input string tag, input logic [N-1:0] actual,
                               input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int pin, input logic val);
        gpio_in_data[pin] = val;
    endtask

    task automatic configPin(input int pin, input logic en, input logic [2:0] mode,
                             input logic fen);
        intr_enable[pin]        = en;
        intr_mode[3*pin +: 3]   = mode;
        filt_enable[pin]        = fen;
    endtask

    initial begin
        rst_n          = 1'b0;
        gpio_in_data   = '0;
        intr_enable    = '0;
        intr_mode      = '0;
        filt_enable    = '0;
        status_clr     = '0;
        filt_threshold = 8'd4;
        configPin(0,   1'b1, 3'b000, 1'b0);
        configPin(5,   1'b1, 3'b000, 1'b0);
        configPin(7,   1'b1, 3'b011, 1'b0);
        configPin(40,  1'b1, 3'b010, 1'b1);
        configPin(63,  1'b1, 3'b010, 1'b1);
        configPin(100, 1'b1, 3'b001, 1'b0);
        configPin(101, 1'b1, 3'b111, 1'b0);
        applyStimulus(5, 1'b1);

        tick(3);
        checkOutput("rst_filt",   gpio_in_filt, '0);
        checkOutput("rst_status", intr_status,  '0);
        checkOutput("rst_group",  N'(group_intr), '0);

        // Prime phase: pin 5 high through reset must not raise a rise event
        rst_n = 1'b1;
        tick(2);
        checkOutput("prime_filt5_e2", N'(gpio_in_filt[5]), 0);
        tick(1);
        checkOutput("prime_filt5_e3", N'(gpio_in_filt[5]), 1);
        tick(3);
        checkOutput("prime_status5", N'(intr_status[5]), 0);

        // Pin 0 rise, filter off: status after 4 edges
        applyStimulus(0, 1'b1);
        tick(3);
        checkOutput("p0_filt_e3",   N'(gpio_in_filt[0]), 1);
        checkOutput("p0_status_e3", N'(intr_status[0]), 0);
        tick(1);
        checkOutput("p0_status_e4", N'(intr_status[0]), 1);
        checkOutput("p0_group0",    N'(group_intr[0]), 1);
        status_clr[0] = 1'b1;
        tick(1);
        status_clr[0] = 1'b0;
        checkOutput("p0_cleared",   N'(intr_status[0]), 0);
        checkOutput("p0_group0_clr", N'(group_intr[0]), 0);

        // Pin 40 both, threshold 4: 3-cycle glitch rejected
        applyStimulus(40, 1'b1);
        tick(3);
        applyStimulus(40, 1'b0);
        tick(8);
        checkOutput("p40_glitch_filt",   N'(gpio_in_filt[40]), 0);
        checkOutput("p40_glitch_status", N'(intr_status[40]), 0);

        // Pin 40: 6-cycle pulse passes, rise then fall
        applyStimulus(40, 1'b1);
        tick(6);
        checkOutput("p40_rise_filt",  N'(gpio_in_filt[40]), 1);
        checkOutput("p40_rise_early", N'(intr_status[40]), 0);
        applyStimulus(40, 1'b0);
        tick(1);
        checkOutput("p40_rise_status", N'(intr_status[40]), 1);
        status_clr[40] = 1'b1;
        tick(1);
        status_clr[40] = 1'b0;
        checkOutput("p40_rise_clr", N'(intr_status[40]), 0);
        tick(4);
        checkOutput("p40_fall_filt",  N'(gpio_in_filt[40]), 0);
        checkOutput("p40_fall_early", N'(intr_status[40]), 0);
        tick(1);
        checkOutput("p40_fall_status", N'(intr_status[40]), 1);
        status_clr[40] = 1'b1;
        tick(1);
        status_clr[40] = 1'b0;
        checkOutput("p40_fall_clr", N'(intr_status[40]), 0);

        // Pin 7 level-high with clear held: level keeps re-setting
        applyStimulus(7, 1'b1);
        status_clr[7] = 1'b1;
        tick(4);
        checkOutput("p7_level_set",  N'(intr_status[7]), 1);
        checkOutput("p7_group0",     N'(group_intr[0]), 1);
        tick(3);
        checkOutput("p7_level_hold", N'(intr_status[7]), 1);
        applyStimulus(7, 1'b0);
        tick(3);
        checkOutput("p7_last_set",   N'(intr_status[7]), 1);
        tick(1);
        checkOutput("p7_cleared",    N'(intr_status[7]), 0);
        status_clr[7] = 1'b0;

        // Pin 100 fall with a clear landing on the setting edge
        applyStimulus(100, 1'b1);
        tick(5);
        checkOutput("p100_no_rise", N'(intr_status[100]), 0);
        applyStimulus(100, 1'b0);
        tick(3);
        status_clr[100] = 1'b1;
        tick(1);
        status_clr[100] = 1'b0;
        checkOutput("p100_set_wins", N'(intr_status[100]), 1);
        checkOutput("p100_group3",   N'(group_intr[3]), 1);

        // Pin 101 reserved mode with a toggling input
        for (int k = 0; k < 10; k++) begin
            applyStimulus(101, ~gpio_in_data[101]);
            tick(1);
        end
        applyStimulus(101, 1'b0);
        tick(4);
        checkOutput("p101_reserved", N'(intr_status[101]), 0);

        // Pin 63: reset while the filter count sits at 2 of 4
        applyStimulus(63, 1'b1);
        tick(4);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_filt",   gpio_in_filt, '0);
        checkOutput("midrst_status", intr_status,  '0);
        checkOutput("midrst_group",  N'(group_intr), '0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        checkOutput("post_rst_status", intr_status, '0);
        checkOutput("post_rst_filt63", N'(gpio_in_filt[63]), 1);
        checkOutput("post_rst_filt0",  N'(gpio_in_filt[0]), 1);
        checkOutput("post_rst_filt5",  N'(gpio_in_filt[5]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_intr_filter_ctrl.md
Name: gpio_intr_filter_ctrl

Overview:
Next-generation GPIO interrupt engine for the GPIO controller. It provides a parametrised pin count and group size, and adds the following per pin:
- input synchroniser
- programmable glitch filter
- five interrupt modes (rise, fall, both, level-high, level-low)
- sticky write-1-to-clear status
- group-level interrupt outputs for the register block and PLIC.

Parameters:
NUM_GPIO, 256, number of GPIO pins
GROUP_SIZE, 32, pins per group interrupt output; NUM_GPIO must be a multiple of GROUP_SIZE
SYNC_STAGES, 2, synchroniser flops per pin (>=2)
FILT_CNT_W, 8, width of the glitch-filter counter and threshold

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
gpio_in_data  input  NUM_GPIO  raw asynchronous pad inputs
intr_enable  input  NUM_GPIO  per-pin detection enable
intr_mode  input  3*NUM_GPIO  per-pin mode, pin i at [3i+:3]
filt_enable  input  NUM_GPIO  per-pin glitch-filter enable
filt_threshold  input  FILT_CNT_W  global stable-cycle count
status_clr  input  NUM_GPIO  write-1-to-clear pulse from the register block
gpio_in_filt  output  NUM_GPIO  synchronised and filtered pin value
intr_status  output  NUM_GPIO  sticky per-pin interrupt status
group_intr  output  NUM_GPIO/GROUP_SIZE  OR of intr_status per group

Behaviour:
- Reset: all synchroniser flops, filt_q (=gpio_in_filt), filt_prev, filter counters and intr_status go to 0; group_intr goes to 0.
- Synchroniser: SYNC_STAGES flops per pin; sync_out is the last stage.
- Effective threshold T = max(filt_threshold, 1). filt_enable=0 forces T=1.
- Filter, per pin:
  - sync_out == filt_q: counter <= 0.
  - Mismatch and counter == T-1 (or counter >= T-1 after a threshold change): filt_q <= sync_out, counter <= 0.
  - Otherwise on mismatch: counter++.
  - A glitch shorter than T cycles never reaches filt_q.
- filt_prev <= filt_q every cycle.
- Modes, evaluated on filt_q/filt_prev:
  - 000 rise: ~prev & q
  - 001 fall: prev & ~q
  - 010 both: prev ^ q
  - 011 level-high: q
  - 100 level-low: ~q
  - 101-111 reserved: never detect.
- Detection is gated by intr_enable.
- Status is registered:
  - intr_status[i] <= det[i] | (intr_status[i] & ~status_clr[i]).
  - Set wins over a same-cycle clear.
  - A level mode re-sets status every cycle while the level persists.
- Disabling a pin stops new sets. Existing status is held until cleared.
- Latency, pad change to intr_status: SYNC_STAGES + T + 1 clk edges. With T=1 and SYNC_STAGES=2 this is 4 edges.
- Prime phase:
  - Lasts SYNC_STAGES+1 cycles after rst_n deassertion.
  - filt_q and filt_prev load sync_out directly, bypassing the filter.
  - All detection is suppressed.
  - Pins held high through reset therefore raise no rise interrupt.
  - A 2-bit-wide-enough prime counter tracks the phase. It saturates and is then idle.
- Config changes to mode, enable or threshold take effect the next cycle. They are never retroactive, and counters are not reset.
- Reset asserted mid-operation returns to the reset state immediately and re-enters the prime phase on release.
- group_intr[g] = |intr_status[g*GROUP_SIZE +: GROUP_SIZE], combinational from registered status.

Decomposition:
- Package gpio_intr_pkg holds:
  - intr_mode_e enum (INTR_RISE=3'b000, INTR_FALL, INTR_BOTH, INTR_LEVEL_HIGH, INTR_LEVEL_LOW)
  - localparam defaults for NUM_GPIO, GROUP_SIZE, SYNC_STAGES, FILT_CNT_W.
- Sub-module gpio_intr_pin_filter holds the synchroniser, counter and filt_q/filt_prev for one pin. It is generated NUM_GPIO times and takes the prime signal as an input.
- The top module holds the prime counter, mode decode, status and group OR.

Test Plan:
- Reset release with pin 5 held high, mode rise -> intr_status[5] stays 0; gpio_in_filt[5]=1 after 3 cycles.
- Pin 0, rise, filt off: 0->1 at cycle 10 -> intr_status[0]=1 at cycle 14 and group_intr[0]=1; pulse status_clr[0] -> status 0 the next cycle.
- Pin 40, both, filt_enable=1, threshold=4:
  - 3-cycle high glitch -> no status, gpio_in_filt stays 0.
  - 6-cycle high pulse -> status set on rise; clear, then status set again on fall.
- Pin 7, level-high, held high, status_clr pulsed every cycle -> status stays 1; drive pin low, clear -> status 0.
- Simultaneous set and clear on pin 100, fall -> status=1. Reserved mode 3'b111 with toggling input -> status never set.
- Assert rst_n mid-filter-count on pin 63 (count at 2 of 4) -> all outputs 0 immediately; after release, no spurious interrupt.
